// File: rtl/ramarb2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ramarb2
// Brief    : Two-master Wishbone arbiter in front of the PSRAM controller.
//            Build option RAMARB_ROUND_ROBIN_EN selects round-robin tie-break.
// Revision : 1.0 - initial release
// ============================================================================
module ramarb2 #(
  parameter int          AW          = 23,
  parameter int          DW          = 16,
  parameter int          SW          = 2,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic          clk2x_i,
  input  logic          reset_i,
  input  logic          ram_busy_i,

  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic [AW:1]   m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,

  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic [AW:1]   m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,

  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [SW-1:0] s_sel_o,
  output logic [AW:1]   s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,

  output logic [1:0]    gnt_o
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_own0 = 2'd1;
  localparam logic [1:0] c_st_own1 = 2'd2;
  localparam logic [1:0] c_st_turn = 2'd3;

  localparam logic [2:0] c_turn_load = 3'(TURN_CYCLES);

  logic [1:0]    state_q, state_d;
  logic [2:0]    turn_cnt_q, turn_cnt_d;
  logic [DW-1:0] m0_dat_q, m0_dat_d;
  logic [DW-1:0] m1_dat_q, m1_dat_d;
  logic          w_own0, w_own1;
  logic          w_tie_to_m1;

`ifdef RAMARB_ROUND_ROBIN_EN
  logic          last_q, last_d;

  // last_q=1 means master 1 owned last, so master 0 takes the next tie.
  assign w_tie_to_m1 = ~last_q;
`else
  assign w_tie_to_m1 = 1'b0;
`endif

  assign w_own0 = (state_q == c_st_own0);
  assign w_own1 = (state_q == c_st_own1);

  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
`ifdef RAMARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    case (state_q)
      c_st_idle: begin
        if (!ram_busy_i) begin
          if (m0_cyc_i && m1_cyc_i) begin
            state_d = w_tie_to_m1 ? c_st_own1 : c_st_own0;
          end else if (m0_cyc_i) begin
            state_d = c_st_own0;
          end else if (m1_cyc_i) begin
            state_d = c_st_own1;
          end
        end
      end
      c_st_own0: begin
        if (!m0_cyc_i) begin
`ifdef RAMARB_ROUND_ROBIN_EN
          last_d = 1'b0;
`endif
          if (c_turn_load == 3'd0) begin
            state_d = c_st_idle;
          end else begin
            state_d    = c_st_turn;
            turn_cnt_d = c_turn_load;
          end
        end
      end
      c_st_own1: begin
        if (!m1_cyc_i) begin
`ifdef RAMARB_ROUND_ROBIN_EN
          last_d = 1'b1;
`endif
          if (c_turn_load == 3'd0) begin
            state_d = c_st_idle;
          end else begin
            state_d    = c_st_turn;
            turn_cnt_d = c_turn_load;
          end
        end
      end
      c_st_turn: begin
        // The final turnaround cycle is the one that sees a count of 1.
        if (turn_cnt_q <= 3'd1) begin
          state_d    = c_st_idle;
          turn_cnt_d = 3'd0;
        end else begin
          turn_cnt_d = turn_cnt_q - 3'd1;
        end
      end
      default: begin
        state_d    = c_st_idle;
        turn_cnt_d = 3'd0;
      end
    endcase
  end

  always_comb begin
    m0_dat_d = (w_own0 && s_ack_i) ? s_dat_i : m0_dat_q;
    m1_dat_d = (w_own1 && s_ack_i) ? s_dat_i : m1_dat_q;
  end

  always_ff @(posedge clk2x_i) begin
    if (reset_i) begin
      state_q    <= c_st_idle;
      turn_cnt_q <= 3'd0;
      m0_dat_q   <= '0;
      m1_dat_q   <= '0;
`ifdef RAMARB_ROUND_ROBIN_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      turn_cnt_q <= turn_cnt_d;
      m0_dat_q   <= m0_dat_d;
      m1_dat_q   <= m1_dat_d;
`ifdef RAMARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  // Slave side is driven only by the current owner; everything else is zero.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    if (w_own0) begin
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_stb_i;
      s_we_o   = m0_we_i;
      s_sel_o  = m0_sel_i;
      s_adr_o  = m0_adr_i;
      s_dat_o  = m0_dat_i;
      m0_ack_o = s_ack_i;
    end else if (w_own1) begin
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_stb_i;
      s_we_o   = m1_we_i;
      s_sel_o  = m1_sel_i;
      s_adr_o  = m1_adr_i;
      s_dat_o  = m1_dat_i;
      m1_ack_o = s_ack_i;
    end
  end

  assign m0_dat_o = w_own0 ? s_dat_i : m0_dat_q;
  assign m1_dat_o = w_own1 ? s_dat_i : m1_dat_q;
  assign gnt_o    = {w_own1, w_own0};

endmodule
`default_nettype wire

// File: tb/tb_ramarb2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ramarb2
// Brief    : Table-driven bench for ramarb2 plus hand sequences for reset,
//            tie-break and zero-turnaround behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ramarb2;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [1:0]  sel;
    logic [22:0] adr;
    logic [15:0] dat;
  } bus_t;

  typedef struct {
    logic        rst;
    logic        busy;
    bus_t        m0;
    bus_t        m1;
    logic        ack;
    logic [15:0] sdat;
    logic [1:0]  e_gnt;
    bus_t        e_s;
    logic        e_ack0;
    logic        e_ack1;
    logic [15:0] e_do0;
    logic [15:0] e_do1;
  } vec_t;

  logic        clk2x_i;
  logic        reset_i;
  logic        ram_busy_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [1:0]  m0_sel_i;
  logic [22:0] m0_adr_i;
  logic [15:0] m0_dat_i, m0_dat_o;
  logic        m0_ack_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [1:0]  m1_sel_i;
  logic [22:0] m1_adr_i;
  logic [15:0] m1_dat_i, m1_dat_o;
  logic        m1_ack_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [1:0]  s_sel_o;
  logic [22:0] s_adr_o;
  logic [15:0] s_dat_o;
  logic [15:0] s_dat_i;
  logic        s_ack_i;
  logic [1:0]  gnt_o;

  // Zero-turnaround instance: shares all inputs, separate outputs.
  logic [15:0] z_m0_dat_o, z_m1_dat_o;
  logic        z_m0_ack_o, z_m1_ack_o;
  logic        z_s_cyc_o, z_s_stb_o, z_s_we_o;
  logic [1:0]  z_s_sel_o;
  logic [22:0] z_s_adr_o;
  logic [15:0] z_s_dat_o;
  logic [1:0]  z_gnt_o;

  int n_checks = 0;
  int n_errors = 0;

  ramarb2 #(.AW(23), .DW(16), .SW(2), .TURN_CYCLES(1)) u_dut (
    .clk2x_i(clk2x_i), .reset_i(reset_i), .ram_busy_i(ram_busy_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  ramarb2 #(.AW(23), .DW(16), .SW(2), .TURN_CYCLES(0)) u_dut_t0 (
    .clk2x_i(clk2x_i), .reset_i(reset_i), .ram_busy_i(ram_busy_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(z_m0_dat_o), .m0_ack_o(z_m0_ack_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(z_m1_dat_o), .m1_ack_o(z_m1_ack_o),
    .s_cyc_o(z_s_cyc_o), .s_stb_o(z_s_stb_o), .s_we_o(z_s_we_o),
    .s_sel_o(z_s_sel_o), .s_adr_o(z_s_adr_o), .s_dat_o(z_s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(z_gnt_o)
  );

  initial clk2x_i = 1'b0;
  always #5 clk2x_i = ~clk2x_i;

  function automatic bus_t mkbus(logic cyc, logic stb, logic we, logic [1:0] sel,
                                 logic [22:0] adr, logic [15:0] dat);
    bus_t b;
    b.cyc = cyc; b.stb = stb; b.we = we; b.sel = sel; b.adr = adr; b.dat = dat;
    return b;
  endfunction

  function automatic vec_t row(logic rst, logic busy, bus_t m0, bus_t m1, logic ack,
                               logic [15:0] sdat, logic [1:0] gnt, bus_t es,
                               logic ack0, logic ack1, logic [15:0] do0, logic [15:0] do1);
    vec_t v;
    v.rst = rst; v.busy = busy; v.m0 = m0; v.m1 = m1; v.ack = ack; v.sdat = sdat;
    v.e_gnt = gnt; v.e_s = es; v.e_ack0 = ack0; v.e_ack1 = ack1;
    v.e_do0 = do0; v.e_do1 = do1;
    return v;
  endfunction

  function automatic logic [79:0] main_out();
    return {gnt_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
            m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o};
  endfunction

  function automatic logic [79:0] t0_out();
    return {z_gnt_o, z_s_cyc_o, z_s_stb_o, z_s_we_o, z_s_sel_o, z_s_adr_o, z_s_dat_o,
            z_m0_ack_o, z_m1_ack_o, z_m0_dat_o, z_m1_dat_o};
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_m0(input bus_t b);
    {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i} = b;
  endtask

  task automatic drive_m1(input bus_t b);
    {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i} = b;
  endtask

  task automatic apply(input vec_t v);
    reset_i    = v.rst;
    ram_busy_i = v.busy;
    drive_m0(v.m0);
    drive_m1(v.m1);
    s_ack_i    = v.ack;
    s_dat_i    = v.sdat;
  endtask

  // Leaves the bench at a falling edge with reset released and both DUTs idle.
  task automatic do_reset();
    @(negedge clk2x_i);
    reset_i    = 1'b1;
    ram_busy_i = 1'b0;
    drive_m0('0);
    drive_m1('0);
    s_ack_i    = 1'b0;
    s_dat_i    = '0;
    @(negedge clk2x_i);
    @(negedge clk2x_i);
    reset_i    = 1'b0;
  endtask

  vec_t        tbl[$];
  bus_t        z, r0;
  logic [1:0]  tie_exp[4];
  logic [1:0]  g;

  function automatic bus_t w1(logic [1:0] sel);
    return mkbus(1'b1, 1'b1, 1'b1, sel, 23'h0002A0, 16'hC0DE);
  endfunction

  initial begin
    z  = mkbus(1'b0, 1'b0, 1'b0, 2'b00, 23'h0, 16'h0);
    r0 = mkbus(1'b1, 1'b1, 1'b0, 2'b11, 23'h000100, 16'h0);

    // Reset state, then a master-0 read acked on its fourth owned cycle.
    tbl.push_back(row(1, 0, z,  z, 0, 16'h0,    2'b00, z,  0, 0, 16'h0,    16'h0));
    tbl.push_back(row(0, 0, r0, z, 0, 16'h0,    2'b00, z,  0, 0, 16'h0,    16'h0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(row(0, 0, r0, z, 0, 16'h0,  2'b01, r0, 0, 0, 16'h0,    16'h0));
    tbl.push_back(row(0, 0, r0, z, 1, 16'hBEEF, 2'b01, r0, 1, 0, 16'hBEEF, 16'h0));
    tbl.push_back(row(0, 0, z,  z, 0, 16'h0,    2'b01, z,  0, 0, 16'h0,    16'h0));
    tbl.push_back(row(0, 0, z,  z, 0, 16'h0,    2'b00, z,  0, 0, 16'hBEEF, 16'h0));
    tbl.push_back(row(0, 0, z,  z, 0, 16'h0,    2'b00, z,  0, 0, 16'hBEEF, 16'h0));
    // Master 1 waits out 20 busy cycles; granted one cycle after busy drops.
    for (int i = 0; i < 20; i++)
      tbl.push_back(row(0, 1, z, w1(2'b10), 0, 16'h0, 2'b00, z, 0, 0, 16'hBEEF, 16'h0));
    tbl.push_back(row(0, 0, z, w1(2'b10), 0, 16'h0, 2'b00, z, 0, 0, 16'hBEEF, 16'h0));
    // Three write beats from master 1 while master 0 waits.
    tbl.push_back(row(0, 0, r0, w1(2'b10), 1, 16'h0001, 2'b10, w1(2'b10), 0, 1, 16'hBEEF, 16'h0001));
    tbl.push_back(row(0, 0, r0, w1(2'b01), 1, 16'h0002, 2'b10, w1(2'b01), 0, 1, 16'hBEEF, 16'h0002));
    tbl.push_back(row(0, 0, r0, w1(2'b11), 1, 16'h0003, 2'b10, w1(2'b11), 0, 1, 16'hBEEF, 16'h0003));
    tbl.push_back(row(0, 0, r0, z, 0, 16'h0,    2'b10, z,  0, 0, 16'hBEEF, 16'h0));
    tbl.push_back(row(0, 0, r0, z, 0, 16'h0,    2'b00, z,  0, 0, 16'hBEEF, 16'h0003));
    tbl.push_back(row(0, 0, r0, z, 0, 16'h0,    2'b00, z,  0, 0, 16'hBEEF, 16'h0003));
    tbl.push_back(row(0, 0, r0, z, 0, 16'h0,    2'b01, r0, 0, 0, 16'h0,    16'h0003));
    tbl.push_back(row(0, 0, r0, z, 1, 16'hCAFE, 2'b01, r0, 1, 0, 16'hCAFE, 16'h0003));
    tbl.push_back(row(0, 0, z,  z, 0, 16'h0,    2'b01, z,  0, 0, 16'h0,    16'h0003));
    tbl.push_back(row(0, 0, z,  z, 0, 16'h0,    2'b00, z,  0, 0, 16'hCAFE, 16'h0003));
    tbl.push_back(row(0, 0, z,  z, 0, 16'h0,    2'b00, z,  0, 0, 16'hCAFE, 16'h0003));
    // Busy rising mid-ownership does not revoke the grant.
    tbl.push_back(row(0, 0, r0, z, 0, 16'h0,    2'b00, z,  0, 0, 16'hCAFE, 16'h0003));
    tbl.push_back(row(0, 1, r0, z, 0, 16'h0,    2'b01, r0, 0, 0, 16'h0,    16'h0003));
    tbl.push_back(row(0, 1, r0, z, 1, 16'h0F0F, 2'b01, r0, 1, 0, 16'h0F0F, 16'h0003));
    tbl.push_back(row(0, 1, z,  z, 0, 16'h0,    2'b01, z,  0, 0, 16'h0,    16'h0003));
    tbl.push_back(row(0, 1, z,  z, 0, 16'h0,    2'b00, z,  0, 0, 16'h0F0F, 16'h0003));
    tbl.push_back(row(0, 0, z,  z, 0, 16'h0,    2'b00, z,  0, 0, 16'h0F0F, 16'h0003));

`ifdef RAMARB_ROUND_ROBIN_EN
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b10; tie_exp[2] = 2'b01; tie_exp[3] = 2'b10;
`else
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b01; tie_exp[2] = 2'b01; tie_exp[3] = 2'b01;
`endif

    reset_i = 1'b1; ram_busy_i = 1'b0; drive_m0('0); drive_m1('0);
    s_ack_i = 1'b0; s_dat_i = '0;
    @(negedge clk2x_i);
    @(negedge clk2x_i);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      #1;
      check($sformatf("row%0d", i), main_out(),
            {tbl[i].e_gnt, tbl[i].e_s, tbl[i].e_ack0, tbl[i].e_ack1,
             tbl[i].e_do0, tbl[i].e_do1});
      @(negedge clk2x_i);
    end

    // Reset while master 0 owns the bus.
    do_reset();
    drive_m0(r0);
    @(negedge clk2x_i);
    #1 check("rst_own0_gnt", 80'(gnt_o), 80'(2'b01));
    reset_i = 1'b1;
    s_ack_i = 1'b1;
    @(negedge clk2x_i);
    #1;
    check("rst_s_cyc", 80'(s_cyc_o), 80'(1'b0));
    check("rst_gnt", 80'(gnt_o), 80'(2'b00));
    check("rst_m0_ack", 80'(m0_ack_o), 80'(1'b0));
    reset_i = 1'b0;
    s_ack_i = 1'b0;
    drive_m0(z);

    // Both masters request continuously across four ownership periods.
    do_reset();
    drive_m0(r0);
    drive_m1(w1(2'b11));
    for (int p = 0; p < 4; p++) begin
      g = 2'b00;
      for (int k = 0; k < 10; k++) begin
        #1;
        g = gnt_o;
        if (g != 2'b00) break;
        @(negedge clk2x_i);
      end
      check($sformatf("tie_period%0d", p), 80'(g), 80'(tie_exp[p]));
      if (g == 2'b01) m0_cyc_i = 1'b0;
      else            m1_cyc_i = 1'b0;
      @(negedge clk2x_i);
      m0_cyc_i = 1'b1;
      m1_cyc_i = 1'b1;
    end
    drive_m0(z);
    drive_m1(z);

    // Back-to-back master-0 cycles: zero-turnaround vs one-cycle turnaround.
    do_reset();
    drive_m0(r0);
    #1;
    check("t0_c1_gnt", 80'(z_gnt_o), 80'(2'b00));
    check("t1_c1_gnt", 80'(gnt_o), 80'(2'b00));
    @(negedge clk2x_i);
    #1;
    check("t0_c2_all", t0_out(), {2'b01, r0, 1'b0, 1'b0, 16'h0, 16'h0});
    check("t1_c2_gnt", 80'(gnt_o), 80'(2'b01));
    m0_cyc_i = 1'b0;
    m0_stb_i = 1'b0;
    #1;
    check("t0_c3", 80'({z_gnt_o, z_s_cyc_o}), 80'({2'b01, 1'b0}));
    @(negedge clk2x_i);
    drive_m0(r0);
    #1;
    check("t0_c4", 80'({z_gnt_o, z_s_cyc_o}), 80'({2'b00, 1'b0}));
    check("t1_c4_gnt", 80'(gnt_o), 80'(2'b00));
    @(negedge clk2x_i);
    #1;
    check("t0_c5", 80'({z_gnt_o, z_s_cyc_o}), 80'({2'b01, 1'b1}));
    check("t1_c5_gnt", 80'(gnt_o), 80'(2'b00));
    @(negedge clk2x_i);
    #1;
    check("t1_c6_gnt", 80'(gnt_o), 80'(2'b01));
    drive_m0(z);
    @(negedge clk2x_i);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
